// File: rtl/regbank_write_arbiter_if.sv
// Request/write/read bundle between requesting units and the register-bank write arbiter.
// Latency: not applicable; this bundle holds wires only.
// Backpressure: requesters hold req_valid, addr and data until their req_ready bit is seen high.
interface regbank_write_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic [3:0]          req_valid;
    logic [4*ADDR_W-1:0] req_addr;
    logic [4*WIDTH-1:0]  req_data;
    logic [3:0]          req_ready;
    logic [1:0]          grant_id;
    logic                busy;
    logic                wr_done;
    logic                err;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WIDTH-1:0]    rd_data;

    // Requester/reader side
    modport master (
        output req_valid, req_addr, req_data, rd_addr,
        input  req_ready, grant_id, busy, wr_done, err, rd_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, rd_addr,
        output req_ready, grant_id, busy, wr_done, err, rd_data
    );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for four requesters that feeds a flip-flop register bank, with one registered read port.
// Latency: 3 cycles per write (IDLE sample, CAPTURE, COMMIT); read data is registered, so rd_data lags rd_addr by one cycle.
// Backpressure: one write is in flight at a time, and req_ready strobes only for the grantee during CAPTURE.
module regbank_write_arbiter #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input logic                   clk,
    input logic                   rst,
    regbank_write_arbiter_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        ptr;
    logic [ADDR_W-1:0] stage_addr;
    logic [WIDTH-1:0]  stage_data;
    logic [WIDTH-1:0]  bank [DEPTH];

    logic [1:0] win_id;
    logic       win_vld;
    logic [1:0] idx;

    // Round-robin pick: the first valid requester scanning upward from ptr, wrapping modulo 4
    always_comb begin
        win_id  = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!win_vld && bus.req_valid[idx]) begin
                win_id  = idx;
                win_vld = 1'b1;
            end
        end
    end

    // Sequencer FSM; every output is registered, so req_valid never reaches req_ready through logic alone
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 2'd0;
            stage_addr    <= '0;
            stage_data    <= '0;
            bus.req_ready <= 4'b0000;
            bus.grant_id  <= 2'd0;
            bus.busy      <= 1'b0;
            bus.wr_done   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.wr_done <= 1'b0;
            bus.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        bus.grant_id  <= win_id;
                        bus.req_ready <= 4'b0001 << win_id;
                        bus.busy      <= 1'b1;
                        state         <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bus.req_ready <= 4'b0000;
                    if (bus.req_valid[bus.grant_id]) begin
                        stage_addr  <= bus.req_addr[bus.grant_id*ADDR_W +: ADDR_W];
                        stage_data  <= bus.req_data[bus.grant_id*WIDTH +: WIDTH];
                        bus.wr_done <= 1'b1;
                        state       <= COMMIT;
                    end else begin
                        // Grantee withdrew: flag it and keep ptr, so the same requester keeps priority
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                COMMIT: begin
                    bus.busy <= 1'b0;
                    ptr      <= bus.grant_id + 2'd1;
                    state    <= IDLE;
                end
                default: begin
                    bus.req_ready <= 4'b0000;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Bank storage: the staged word is written at the edge that ends COMMIT; reset aborts the write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == COMMIT) begin
            bank[stage_addr] <= stage_data;
        end
    end

    // Registered read port; a read at the commit edge still returns the old word
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= bank[bus.rd_addr];
        end
    end
endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin write arbiter and sequencer for a small register bank built from D flip-flop cells. Four requesters compete for a single write path. The block grants one requester at a time, captures its address and data, and commits the word into the bank on a later clock edge. It sits between the requesting units and the flip-flop storage, and also provides one registered read port.

## Interface
- WIDTH, 8, data width of each bank word
- ADDR_W, 2, address width; bank depth is 2**ADDR_W words
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  per-requester write request; bit i belongs to requester i
- req_addr  input  4*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
- req_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- req_ready  output  4  one-hot acceptance strobe; high only in CAPTURE, for the granted requester
- grant_id  output  2  index of the current or most recent grantee
- busy  output  1  high in CAPTURE and COMMIT
- wr_done  output  1  one-cycle pulse in the COMMIT cycle
- err  output  1  one-cycle pulse when a grantee drops valid before acceptance
- rd_addr  input  ADDR_W  read address
- rd_data  output  WIDTH  registered read data

## Operation
- State machine has three states: IDLE, CAPTURE and COMMIT.
- IDLE, any req_valid high:
  - Pick the winner by round robin: the first set bit scanning ptr, ptr+1, … mod 4.
  - Register the one-hot grant and grant_id, then go to CAPTURE.
- IDLE, no request: stay in IDLE.
- CAPTURE:
  - req_ready equals the registered grant.
  - If req_valid[grant_id] is high, latch that requester's addr and data into staging registers and go to COMMIT.
  - If it is low, pulse err, make no write, leave ptr unchanged and return to IDLE.
- COMMIT:
  - Write the staged data to the staged address in the bank and pulse wr_done.
  - Set ptr to (grant_id+1) mod 4, then return to IDLE.
- Requester protocol:
  - Once req_valid is asserted, valid, addr and data stay stable until the cycle in which req_ready is high for that requester.
  - The request is consumed in that cycle.
- Requests arriving during CAPTURE or COMMIT are only considered in the next IDLE cycle.
- Only the granted requester ever sees req_ready; all other bits are 0.
- Read port: rd_data updates to bank[rd_addr] every cycle in every state.
- Reset values:
  - State IDLE, ptr 0, and every bank word 0.
  - req_ready 0, grant_id 0, busy 0, wr_done 0, err 0, rd_data 0.
- Reset asserted mid-operation (CAPTURE or COMMIT) aborts the transfer with no bank write. All reset values apply at the next edge.

## Timing
- The full write sequence takes 3 cycles:
  - Edge 0 (IDLE) samples valid.
  - req_ready is high during cycle 1 (CAPTURE).
  - The bank is written at the edge ending cycle 2 (COMMIT).
- Maximum throughput is one write per 3 cycles.
- A requester held continuously valid with no competition is accepted every 3 cycles.
- Write-to-read latency:
  - A read of the written address returns the new data on rd_data 1 cycle after the COMMIT edge.
  - A read at the COMMIT edge itself returns the old data.
- Round-robin fairness: with all four requesters continuously valid after reset, grants occur in the order 0,1,2,3,0,…
- ptr advances only on a successful COMMIT, never on err.
- The grant registered in IDLE uses req_valid sampled at that same edge. There is no combinational path from req_valid to req_ready.

## Test plan
- Reset, then scan rd_addr 0..3:
  - rd_data reads 0 for every address.
  - req_ready, busy, wr_done and err stay 0.
- Requester 2 writes 0xA5 to addr 1:
  - req_ready = 4'b0100 exactly in the second cycle after valid.
  - wr_done pulses in the third cycle.
  - rd_addr=1 reads 0xA5 one cycle later.
- All four requesters valid continuously, each writing data 0x10+i to addr i:
  - Grants 0,1,2,3 follow in order, 3 cycles apart.
  - Final bank reads 0x10, 0x11, 0x12, 0x13.
- Requesters 1 and 3 valid after a completed grant to 1 (ptr=2):
  - Requester 3 wins first, then requester 1.
- Grantee 0 drops valid during CAPTURE:
  - err pulses once, wr_done stays 0 and the bank is unchanged.
  - The next grant goes to requester 0 again if it re-asserts, since ptr stays 0.
- rst asserted during COMMIT of 0xFF to addr 2:
  - addr 2 reads 0, and every output returns to its reset value on the next cycle.
